// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the Apple-1 PS/2 keyboard: scancode set 2 values,
// Apple-1 ASCII codes, receiver state encoding and small helpers.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] ASCII_CR     = 8'h8D;
  localparam logic [7:0] ASCII_RUBOUT = 8'hDF;
  localparam logic [7:0] ASCII_ESC    = 8'h9B;
  localparam logic [7:0] ASCII_SPACE  = 8'hA0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
  } xlate_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: line synchronizers, run-length glitch filters,
// start/data/parity/stop FSM and an inactivity timeout for torn frames.
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 14000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]     clk_sync_r;
  logic [1:0]     data_sync_r;
  logic           clk_filt_r;
  logic           data_filt_r;
  logic           clk_filt_d_r;
  logic [FCW-1:0] clk_cnt_r;
  logic [FCW-1:0] data_cnt_r;
  logic [1:0]     state_r;
  logic [2:0]     bit_cnt_r;
  logic [7:0]     shift_r;
  logic           parity_r;
  logic [TCW-1:0] tmo_r;
  logic           fall_s;

  assign fall_s = clk_filt_d_r & ~clk_filt_r;

  // Two-flop synchronizers; idle PS/2 lines float high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Run filters: a line only changes after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt_r   <= 1'b1;
      data_filt_r  <= 1'b1;
      clk_filt_d_r <= 1'b1;
      clk_cnt_r    <= '0;
      data_cnt_r   <= '0;
    end else begin
      clk_filt_d_r <= clk_filt_r;
      if (clk_sync_r[1] == clk_filt_r) begin
        clk_cnt_r <= '0;
      end else if (clk_cnt_r == FCW'(FILTER_LEN - 1)) begin
        clk_filt_r <= clk_sync_r[1];
        clk_cnt_r  <= '0;
      end else begin
        clk_cnt_r <= clk_cnt_r + FCW'(1);
      end
      if (data_sync_r[1] == data_filt_r) begin
        data_cnt_r <= '0;
      end else if (data_cnt_r == FCW'(FILTER_LEN - 1)) begin
        data_filt_r <= data_sync_r[1];
        data_cnt_r  <= '0;
      end else begin
        data_cnt_r <= data_cnt_r + FCW'(1);
      end
    end
  end

  // Frame FSM, advanced on each filtered clock falling edge, with timeout recovery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      tmo_r     <= '0;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (fall_s) begin
        tmo_r <= '0;
        case (state_r)
          ST_IDLE: begin
            if (!data_filt_r) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_r   <= {data_filt_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_r <= data_filt_r;
            state_r  <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (data_filt_r && odd_parity_ok(shift_r, parity_r)) begin
              rx_byte  <= shift_r;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (state_r != ST_IDLE) begin
        // A stalled partial frame is dropped silently so the next frame starts clean.
        if (tmo_r == TCW'(TIMEOUT_CYCLES - 1)) begin
          state_r <= ST_IDLE;
          tmo_r   <= '0;
        end else begin
          tmo_r <= tmo_r + TCW'(1);
        end
      end else begin
        tmo_r <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// Apple-1 keyboard: PS/2 scancode decode and translation into a single-entry
// key register read through a PIA-style KBD/KBDCR pair; F1 drives clr_screen.
module ps2_keyboard
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 14000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       address,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic       clr_screen,
  output logic       frame_err
);

  logic [7:0] rx_byte_s;
  logic       rx_valid_s;
  logic       ext_pend_r;
  logic       brk_pend_r;
  logic       shift_r;
  logic       ctrl_r;
  logic       clr_screen_r;
  logic [7:0] key_data_r;
  logic       key_ready_r;
  logic       read_seen_r;
  xlate_t     xl_s;
  logic       key_load_s;
  logic       rd_clr_s;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte_s),
    .rx_valid  (rx_valid_s),
    .frame_err (frame_err)
  );

  // Scancode set 2 to Apple-1 ASCII; letters are uppercase only, Ctrl folds letters.
  function automatic xlate_t xlate(input logic [7:0] sc, input logic sh, input logic ct);
    xlate_t res;
    res.hit = 1'b1;
    res.ch  = 8'h00;
    case (sc)
      8'h1C: res.ch = 8'hC1;  8'h32: res.ch = 8'hC2;  8'h21: res.ch = 8'hC3;
      8'h23: res.ch = 8'hC4;  8'h24: res.ch = 8'hC5;  8'h2B: res.ch = 8'hC6;
      8'h34: res.ch = 8'hC7;  8'h33: res.ch = 8'hC8;  8'h43: res.ch = 8'hC9;
      8'h3B: res.ch = 8'hCA;  8'h42: res.ch = 8'hCB;  8'h4B: res.ch = 8'hCC;
      8'h3A: res.ch = 8'hCD;  8'h31: res.ch = 8'hCE;  8'h44: res.ch = 8'hCF;
      8'h4D: res.ch = 8'hD0;  8'h15: res.ch = 8'hD1;  8'h2D: res.ch = 8'hD2;
      8'h1B: res.ch = 8'hD3;  8'h2C: res.ch = 8'hD4;  8'h3C: res.ch = 8'hD5;
      8'h2A: res.ch = 8'hD6;  8'h1D: res.ch = 8'hD7;  8'h22: res.ch = 8'hD8;
      8'h35: res.ch = 8'hD9;  8'h1A: res.ch = 8'hDA;
      8'h16: res.ch = sh ? 8'hA1 : 8'hB1;
      8'h1E: res.ch = sh ? 8'hC0 : 8'hB2;
      8'h26: res.ch = sh ? 8'hA3 : 8'hB3;
      8'h25: res.ch = sh ? 8'hA4 : 8'hB4;
      8'h2E: res.ch = sh ? 8'hA5 : 8'hB5;
      8'h36: res.ch = sh ? 8'hDE : 8'hB6;
      8'h3D: res.ch = sh ? 8'hA6 : 8'hB7;
      8'h3E: res.ch = sh ? 8'hAA : 8'hB8;
      8'h46: res.ch = sh ? 8'hA8 : 8'hB9;
      8'h45: res.ch = sh ? 8'hA9 : 8'hB0;
      SC_ENTER: res.ch = ASCII_CR;
      SC_BKSP:  res.ch = ASCII_RUBOUT;
      SC_ESC:   res.ch = ASCII_ESC;
      SC_SPACE: res.ch = ASCII_SPACE;
      default:  res.hit = 1'b0;
    endcase
    // Letters occupy C1..DA exactly, so the range test identifies them.
    if (ct && (res.ch >= 8'hC1) && (res.ch <= 8'hDA)) begin
      res.ch = res.ch & 8'h9F;
    end
    return res;
  endfunction

  assign xl_s       = xlate(rx_byte_s, shift_r, ctrl_r);
  assign key_load_s = rx_valid_s & ~ext_pend_r & ~brk_pend_r & xl_s.hit;
  assign rd_clr_s   = enable & r_en & ~address & ~read_seen_r;
  assign clr_screen = clr_screen_r;

  // Prefix tracking and modifier/F1 state updates on each received byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend_r   <= 1'b0;
      brk_pend_r   <= 1'b0;
      shift_r      <= 1'b0;
      ctrl_r       <= 1'b0;
      clr_screen_r <= 1'b0;
    end else if (rx_valid_s) begin
      if (rx_byte_s == SC_EXT) begin
        ext_pend_r <= 1'b1;
      end else if (rx_byte_s == SC_BRK) begin
        brk_pend_r <= 1'b1;
      end else begin
        ext_pend_r <= 1'b0;
        brk_pend_r <= 1'b0;
        if (rx_byte_s == SC_CTRL) begin
          ctrl_r <= ~brk_pend_r;
        end else if (!ext_pend_r) begin
          if ((rx_byte_s == SC_LSHIFT) || (rx_byte_s == SC_RSHIFT)) begin
            shift_r <= ~brk_pend_r;
          end else if (rx_byte_s == SC_F1) begin
            clr_screen_r <= ~brk_pend_r;
          end
        end
      end
    end
  end

  // Key hold register; a new key beats a read-clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_data_r  <= 8'h00;
      key_ready_r <= 1'b0;
      read_seen_r <= 1'b0;
    end else begin
      if (key_load_s) begin
        key_data_r  <= xl_s.ch;
        key_ready_r <= 1'b1;
      end else if (rd_clr_s) begin
        key_ready_r <= 1'b0;
      end
      if (!r_en) begin
        read_seen_r <= 1'b0;
      end else if (rd_clr_s) begin
        read_seen_r <= 1'b1;
      end
    end
  end

  // KBD / KBDCR read mux.
  always_comb begin
    dout = 8'h00;
    if (address) begin
      dout = {key_ready_r, 7'b0000000};
    end else begin
      dout = {1'b1, key_data_r[6:0]};
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomized and directed bench for ps2_keyboard against a table-driven key model.
module tb_ps2_keyboard;

  localparam int HALF = 25;
  localparam int TMO  = 14000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ps2_clk;
  logic       ps2_data;
  logic       address;
  logic       r_en;
  logic [7:0] dout;
  logic       clr_screen;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .address    (address),
    .r_en       (r_en),
    .dout       (dout),
    .clr_screen (clr_screen),
    .frame_err  (frame_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int ferr_cycles  = 0;

  always @(negedge clk) if (frame_err === 1'b1) ferr_cycles <= ferr_cycles + 1;

  // Reference key tables, built from the US layout.
  string      letters  = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  bit [7:0]   letter_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                 8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                 8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  string      digits   = "1234567890";
  string      shifted  = "!@#$%^&*()";
  bit [7:0]   digit_sc [10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
  bit [7:0]   base_map  [bit [7:0]];
  bit [7:0]   shift_map [bit [7:0]];
  bit         is_letter [bit [7:0]];
  bit [7:0]   keys_q [$];

  bit         m_ext, m_brk, m_shift, m_ctrl, m_clr, m_ready;
  bit [7:0]   m_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_shift = 1'b0; m_ctrl = 1'b0;
    m_clr = 1'b0; m_ready = 1'b0; m_data = 8'h00;
  endtask

  function automatic bit [7:0] lookup(input bit [7:0] sc);
    bit [7:0] ch;
    ch = (m_shift && shift_map.exists(sc)) ? shift_map[sc] : base_map[sc];
    if (m_ctrl && is_letter.exists(sc)) ch = ch & 8'h9F;
    return ch;
  endfunction

  task automatic model_byte(input bit [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (b == 8'h14) m_ctrl = ~m_brk;
      else if (!m_ext) begin
        if (b == 8'h12 || b == 8'h59) m_shift = ~m_brk;
        else if (b == 8'h05) m_clr = ~m_brk;
        else if (!m_brk && base_map.exists(b)) begin
          m_data  = lookup(b);
          m_ready = 1'b1;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic check_read(input string tag, input logic a);
    logic [7:0] exp;
    logic [7:0] got;
    exp = a ? {m_ready, 7'b0000000} : (8'h80 | m_data);
    @(negedge clk);
    address = a;
    r_en    = 1'b1;
    #1 got = dout;
    @(negedge clk);
    r_en = 1'b0;
    if (!a) m_ready = 1'b0;
    check_eq(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    int f0;
    bit seen;
    for (int i = 0; i < 26; i++) begin
      base_map[letter_sc[i]]  = 8'h80 | 8'(letters[i]);
      is_letter[letter_sc[i]] = 1'b1;
      keys_q.push_back(letter_sc[i]);
    end
    for (int i = 0; i < 10; i++) begin
      base_map[digit_sc[i]]  = 8'h80 | 8'(digits[i]);
      shift_map[digit_sc[i]] = 8'h80 | 8'(shifted[i]);
      keys_q.push_back(digit_sc[i]);
    end
    base_map[8'h5A] = 8'h8D; base_map[8'h66] = 8'hDF;
    base_map[8'h76] = 8'h9B; base_map[8'h29] = 8'hA0;
    keys_q.push_back(8'h5A); keys_q.push_back(8'h66);
    keys_q.push_back(8'h76); keys_q.push_back(8'h29);

    rst = 1'b1; enable = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; address = 1'b0; r_en = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1 check_eq("rst_kbd", 32'(dout), 32'h80);
    address = 1'b1;
    #1 check_eq("rst_kbdcr", 32'(dout), 32'h00);
    check_eq("rst_clr", 32'(clr_screen), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);

    // Reset in the middle of a frame.
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    rst = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);

    send_key(8'h1C);
    check_read("a_ready", 1'b1);
    check_read("a_data", 1'b0);
    check_read("a_cleared", 1'b1);

    send_key(8'h12); send_key(8'h16);
    check_read("shift1_data", 1'b0);
    send_key(8'hF0); send_key(8'h16); send_key(8'hF0); send_key(8'h12);
    check_read("break_noload", 1'b1);
    check_read("shift1_hold", 1'b0);
    send_key(8'h16);
    check_read("unshift1_data", 1'b0);

    f0 = ferr_cycles;
    send_frame(8'h1C, 1'b1);
    check_eq("bad_par_pulse", 32'(ferr_cycles - f0), 32'd1);
    check_read("bad_par_noready", 1'b1);
    send_key(8'h5A);
    check_read("enter_data", 1'b0);

    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 10) @(negedge clk);
    send_key(8'h66);
    check_read("timeout_rubout", 1'b0);

    send_key(8'h05);
    check_eq("f1_make", 32'(clr_screen), 32'(m_clr));
    send_key(8'hF0); send_key(8'h05);
    check_eq("f1_break", 32'(clr_screen), 32'(m_clr));

    send_key(8'h14); send_key(8'h21);
    check_read("ctrl_c", 1'b0);
    send_key(8'hF0); send_key(8'h14);

    // Key load and read-clear landing on the same clock.
    seen = 1'b0;
    fork
      send_frame(8'h1C, 1'b0);
      begin
        for (int i = 0; i < 2000 && !seen; i++) begin
          @(negedge clk);
          if (dut.u_rx.rx_valid === 1'b1) begin
            seen = 1'b1;
            address = 1'b0;
            r_en = 1'b1;
            @(negedge clk);
            r_en = 1'b0;
          end
        end
      end
    join
    model_byte(8'h1C);
    check_eq("collide_seen", 32'(seen), 32'd1);
    check_read("collide_ready", 1'b1);
    check_read("collide_data", 1'b0);

    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      case (r)
        5: b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        6: b = 8'h14;
        7: b = 8'hF0;
        8: b = 8'hE0;
        9: case ($urandom_range(0, 3))
             0: b = 8'h05;
             1: b = 8'h07;
             2: b = 8'h7E;
             default: b = 8'h0E;
           endcase
        default: b = keys_q[$urandom_range(0, keys_q.size() - 1)];
      endcase
      send_key(b);
      check_eq("rnd_clr", 32'(clr_screen), 32'(m_clr));
      if ($urandom_range(0, 2) == 0) begin
        check_read("rnd_kbdcr", 1'b1);
        check_read("rnd_kbd", 1'b0);
      end
    end
    check_read("end_kbdcr", 1'b1);
    check_read("end_kbd", 1'b0);
    check_eq("ferr_total", 32'(ferr_cycles), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
